// File: rtl/page_walk_arbiter_if.sv
// Bundle of requester, walker and result signals around the page-walk arbiter.
// The slave modport faces the arbiter; master faces requesters and the walker.
interface page_walk_arbiter_if #(
    parameter int NUM_RQ = 3
);
    localparam int IDW = $clog2(NUM_RQ);

    logic [NUM_RQ-1:0]    IN_rqValid;
    logic [NUM_RQ*20-1:0] IN_rqVPN;
    logic [NUM_RQ-1:0]    IN_cancel;
    logic                 IN_flushAll;
    logic [21:0]          IN_rootPPN;
    logic [1:0]           IN_priv;
    logic                 IN_sum;
    logic                 IN_mxr;

    logic                 OUT_busy;
    logic [IDW-1:0]       OUT_rqID;

    logic                 OUT_walkValid;
    logic [19:0]          OUT_walkVPN;
    logic [21:0]          OUT_walkRootPPN;
    logic [1:0]           OUT_walkPriv;
    logic                 OUT_walkSum;
    logic                 OUT_walkMxr;
    logic                 IN_walkReady;
    logic                 IN_walkDone;
    logic [21:0]          IN_walkPPN;
    logic                 IN_walkSuper;
    logic                 IN_walkFault;

    logic                 OUT_resValid;
    logic [IDW-1:0]       OUT_resID;
    logic [21:0]          OUT_resPPN;
    logic                 OUT_resSuper;
    logic                 OUT_resFault;

    modport slave (
        input  IN_rqValid, IN_rqVPN, IN_cancel, IN_flushAll,
        input  IN_rootPPN, IN_priv, IN_sum, IN_mxr,
        output OUT_busy, OUT_rqID,
        output OUT_walkValid, OUT_walkVPN, OUT_walkRootPPN, OUT_walkPriv,
        output OUT_walkSum, OUT_walkMxr,
        input  IN_walkReady, IN_walkDone, IN_walkPPN, IN_walkSuper, IN_walkFault,
        output OUT_resValid, OUT_resID, OUT_resPPN, OUT_resSuper, OUT_resFault
    );

    modport master (
        output IN_rqValid, IN_rqVPN, IN_cancel, IN_flushAll,
        output IN_rootPPN, IN_priv, IN_sum, IN_mxr,
        input  OUT_busy, OUT_rqID,
        input  OUT_walkValid, OUT_walkVPN, OUT_walkRootPPN, OUT_walkPriv,
        input  OUT_walkSum, OUT_walkMxr,
        output IN_walkReady, IN_walkDone, IN_walkPPN, IN_walkSuper, IN_walkFault,
        input  OUT_resValid, OUT_resID, OUT_resPPN, OUT_resSuper, OUT_resFault
    );
endinterface

// File: rtl/page_walk_arbiter.sv
// Round-robin arbiter sharing one page walker among NUM_RQ translation requesters,
// with per-owner cancel and global flush; results are tagged with the owner ID.
module page_walk_arbiter #(
    parameter int NUM_RQ = 3
) (
    input  logic              clk,
    input  logic              rst,
    page_walk_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_RQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic           squash_q, squash_d;
    logic           busy_q, walk_valid_q, res_valid_q, res_valid_d;
    logic [IDW-1:0] owner_q, res_id_q;
    logic [19:0]    vpn_q;
    logic [21:0]    root_q, res_ppn_q;
    logic [1:0]     priv_q;
    logic           sum_q, mxr_q, res_super_q, res_fault_q;

    logic [NUM_RQ-1:0] cand;
    logic [IDW:0]      scan_idx;
    logic [IDW-1:0]    grant_id;
    logic              grant_found, grant, kill;

    assign cand = bus.IN_flushAll ? '0 : (bus.IN_rqValid & ~bus.IN_cancel);
    assign kill = bus.IN_cancel[owner_q] | bus.IN_flushAll;

    // First candidate scanning upward from rr_q with wrap-around.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_RQ; k++) begin
            scan_idx = {1'b0, rr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NUM_RQ))
                scan_idx = scan_idx - (IDW+1)'(NUM_RQ);
            if (!grant_found && cand[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        squash_d    = squash_q;
        res_valid_d = 1'b0;
        grant       = 1'b0;
        case (state_q)
            S_IDLE: begin
                squash_d = 1'b0;
                if (grant_found) begin
                    grant   = 1'b1;
                    state_d = S_ISSUE;
                    rr_d    = (grant_id == IDW'(NUM_RQ-1)) ? '0 : grant_id + 1'b1;
                end
            end
            S_ISSUE: begin
                // An abandoned request is treated as never issued, even if ready.
                if (kill)
                    state_d = S_IDLE;
                else if (bus.IN_walkReady)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.IN_walkDone) begin
                    state_d     = S_IDLE;
                    squash_d    = 1'b0;
                    res_valid_d = !squash_q && !kill;
                end else if (kill) begin
                    squash_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            squash_q     <= 1'b0;
            busy_q       <= 1'b0;
            walk_valid_q <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            squash_q     <= squash_d;
            busy_q       <= (state_d != S_IDLE);
            walk_valid_q <= (state_d == S_ISSUE);
            res_valid_q  <= res_valid_d;
        end
    end

    // Payload registers carry no reset; they are only meaningful behind the valids.
    always_ff @(posedge clk) begin
        if (grant) begin
            owner_q <= grant_id;
            vpn_q   <= bus.IN_rqVPN[20*grant_id +: 20];
            root_q  <= bus.IN_rootPPN;
            priv_q  <= bus.IN_priv;
            sum_q   <= bus.IN_sum;
            mxr_q   <= bus.IN_mxr;
        end
        if (res_valid_d) begin
            res_id_q    <= owner_q;
            res_ppn_q   <= bus.IN_walkPPN;
            res_super_q <= bus.IN_walkSuper;
            res_fault_q <= bus.IN_walkFault;
        end
    end

    assign bus.OUT_busy        = busy_q;
    assign bus.OUT_rqID        = owner_q;
    assign bus.OUT_walkValid   = walk_valid_q;
    assign bus.OUT_walkVPN     = vpn_q;
    assign bus.OUT_walkRootPPN = root_q;
    assign bus.OUT_walkPriv    = priv_q;
    assign bus.OUT_walkSum     = sum_q;
    assign bus.OUT_walkMxr     = mxr_q;
    assign bus.OUT_resValid    = res_valid_q;
    assign bus.OUT_resID       = res_id_q;
    assign bus.OUT_resPPN      = res_ppn_q;
    assign bus.OUT_resSuper    = res_super_q;
    assign bus.OUT_resFault    = res_fault_q;
endmodule

// File: tb/tb_page_walk_arbiter.sv
// Directed bench for page_walk_arbiter: grant order, cancel/flush squashing and reset.
module tb_page_walk_arbiter;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [19:0] vpn_tab [3];

    page_walk_arbiter_if #(.NUM_RQ(3)) bus ();

    page_walk_arbiter #(.NUM_RQ(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for a grant, checks owner/VPN, then completes the walk.
    task automatic walk_once(input int exp_id, input logic [21:0] ppn);
        int n;
        n = 0;
        while (!bus.OUT_busy && n < 4) begin
            tick();
            n++;
        end
        check_eq("grant_seen", 32'(bus.OUT_busy), 32'd1);
        check_eq("grant_id", 32'(bus.OUT_rqID), 32'(exp_id));
        check_eq("grant_vpn", 32'(bus.OUT_walkVPN), 32'(vpn_tab[exp_id]));
        bus.IN_walkReady = 1'b1;
        tick();
        bus.IN_walkReady = 1'b0;
        bus.IN_walkDone  = 1'b1;
        bus.IN_walkPPN   = ppn;
        tick();
        bus.IN_walkDone  = 1'b0;
        check_eq("walk_resValid", 32'(bus.OUT_resValid), 32'd1);
        check_eq("walk_resID", 32'(bus.OUT_resID), 32'(exp_id));
        check_eq("walk_resPPN", 32'(bus.OUT_resPPN), 32'(ppn));
        $display("[TB] walk rq=%0d ppn=0x%0h", bus.OUT_resID, bus.OUT_resPPN);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        vpn_tab[0] = 20'h12345;
        vpn_tab[1] = 20'h23456;
        vpn_tab[2] = 20'h34567;
        rst = 1'b1;
        bus.IN_rqValid   = '0;
        bus.IN_rqVPN     = {vpn_tab[2], vpn_tab[1], vpn_tab[0]};
        bus.IN_cancel    = '0;
        bus.IN_flushAll  = 1'b0;
        bus.IN_rootPPN   = 22'h2ABCDE;
        bus.IN_priv      = 2'd1;
        bus.IN_sum       = 1'b1;
        bus.IN_mxr       = 1'b0;
        bus.IN_walkReady = 1'b0;
        bus.IN_walkDone  = 1'b0;
        bus.IN_walkPPN   = '0;
        bus.IN_walkSuper = 1'b0;
        bus.IN_walkFault = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_busy", 32'(bus.OUT_busy), 32'd0);
        check_eq("rst_walkValid", 32'(bus.OUT_walkValid), 32'd0);
        check_eq("rst_resValid", 32'(bus.OUT_resValid), 32'd0);

        // 1: single walk from IFetch
        bus.IN_rqValid = 3'b001;
        tick();
        bus.IN_rqValid = 3'b000;
        check_eq("t1_busy", 32'(bus.OUT_busy), 32'd1);
        check_eq("t1_rqID", 32'(bus.OUT_rqID), 32'd0);
        check_eq("t1_walkValid", 32'(bus.OUT_walkValid), 32'd1);
        check_eq("t1_walkVPN", 32'(bus.OUT_walkVPN), 32'h12345);
        check_eq("t1_root", 32'(bus.OUT_walkRootPPN), 32'h2ABCDE);
        check_eq("t1_priv", 32'(bus.OUT_walkPriv), 32'd1);
        check_eq("t1_sum", 32'(bus.OUT_walkSum), 32'd1);
        check_eq("t1_mxr", 32'(bus.OUT_walkMxr), 32'd0);
        tick();
        check_eq("t1_hold_valid", 32'(bus.OUT_walkValid), 32'd1);
        check_eq("t1_hold_vpn", 32'(bus.OUT_walkVPN), 32'h12345);
        bus.IN_walkReady = 1'b1;
        tick();
        bus.IN_walkReady = 1'b0;
        check_eq("t1_issued_valid", 32'(bus.OUT_walkValid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t1_wait_resValid", 32'(bus.OUT_resValid), 32'd0);
            check_eq("t1_wait_busy", 32'(bus.OUT_busy), 32'd1);
        end
        bus.IN_walkDone  = 1'b1;
        bus.IN_walkPPN   = 22'h0ABCD;
        bus.IN_walkSuper = 1'b1;
        bus.IN_walkFault = 1'b0;
        tick();
        bus.IN_walkDone  = 1'b0;
        bus.IN_walkSuper = 1'b0;
        check_eq("t1_resValid", 32'(bus.OUT_resValid), 32'd1);
        check_eq("t1_resID", 32'(bus.OUT_resID), 32'd0);
        check_eq("t1_resPPN", 32'(bus.OUT_resPPN), 32'h0ABCD);
        check_eq("t1_resSuper", 32'(bus.OUT_resSuper), 32'd1);
        check_eq("t1_resFault", 32'(bus.OUT_resFault), 32'd0);
        check_eq("t1_busy_at_res", 32'(bus.OUT_busy), 32'd0);
        $display("[TB] walk rq=%0d ppn=0x%0h", bus.OUT_resID, bus.OUT_resPPN);
        tick();
        check_eq("t1_res_pulse", 32'(bus.OUT_resValid), 32'd0);

        // 2: round-robin 0,1,2 then wrap to 0 (reset first to bring rrPtr to 0)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.IN_rqValid = 3'b111;
        walk_once(0, 22'h00100);
        walk_once(1, 22'h00201);
        walk_once(2, 22'h00302);
        walk_once(0, 22'h00400);
        bus.IN_rqValid = 3'b000;

        // 3: owner 1 cancels in ISSUE; pending rq 2 granted afterwards
        bus.IN_rqValid = 3'b110;
        tick();
        check_eq("t3_rqID", 32'(bus.OUT_rqID), 32'd1);
        bus.IN_cancel  = 3'b010;
        bus.IN_rqValid = 3'b100;
        tick();
        bus.IN_cancel  = 3'b000;
        check_eq("t3_cancel_valid", 32'(bus.OUT_walkValid), 32'd0);
        check_eq("t3_cancel_busy", 32'(bus.OUT_busy), 32'd0);
        check_eq("t3_cancel_res", 32'(bus.OUT_resValid), 32'd0);
        tick();
        bus.IN_rqValid = 3'b000;
        check_eq("t3_regrant_busy", 32'(bus.OUT_busy), 32'd1);
        check_eq("t3_regrant_id", 32'(bus.OUT_rqID), 32'd2);
        bus.IN_cancel = 3'b001;
        tick();
        bus.IN_cancel = 3'b000;
        check_eq("t3_nonowner_valid", 32'(bus.OUT_walkValid), 32'd1);
        bus.IN_walkReady = 1'b1;
        tick();
        bus.IN_walkReady = 1'b0;
        bus.IN_walkDone  = 1'b1;
        bus.IN_walkPPN   = 22'h3F00F;
        tick();
        bus.IN_walkDone  = 1'b0;
        check_eq("t3_resValid", 32'(bus.OUT_resValid), 32'd1);
        check_eq("t3_resID", 32'(bus.OUT_resID), 32'd2);
        $display("[TB] walk rq=%0d ppn=0x%0h", bus.OUT_resID, bus.OUT_resPPN);

        // 4: flushAll during WAIT squashes the eventual result
        bus.IN_rqValid = 3'b001;
        tick();
        bus.IN_rqValid = 3'b000;
        check_eq("t4_rqID", 32'(bus.OUT_rqID), 32'd0);
        bus.IN_walkReady = 1'b1;
        tick();
        bus.IN_walkReady = 1'b0;
        bus.IN_flushAll = 1'b1;
        tick();
        bus.IN_flushAll = 1'b0;
        check_eq("t4_busy_after_flush", 32'(bus.OUT_busy), 32'd1);
        tick();
        tick();
        check_eq("t4_busy_before_done", 32'(bus.OUT_busy), 32'd1);
        bus.IN_walkDone = 1'b1;
        tick();
        bus.IN_walkDone = 1'b0;
        check_eq("t4_squashed_res", 32'(bus.OUT_resValid), 32'd0);
        check_eq("t4_busy_after_done", 32'(bus.OUT_busy), 32'd0);
        bus.IN_rqValid = 3'b010;
        tick();
        bus.IN_rqValid = 3'b000;
        check_eq("t4_newgrant_busy", 32'(bus.OUT_busy), 32'd1);
        check_eq("t4_newgrant_id", 32'(bus.OUT_rqID), 32'd1);
        bus.IN_walkReady = 1'b1;
        tick();
        bus.IN_walkReady = 1'b0;
        bus.IN_walkDone  = 1'b1;
        bus.IN_walkPPN   = 22'h01111;
        tick();
        bus.IN_walkDone  = 1'b0;
        check_eq("t4_resValid", 32'(bus.OUT_resValid), 32'd1);
        check_eq("t4_resID", 32'(bus.OUT_resID), 32'd1);
        $display("[TB] walk rq=%0d ppn=0x%0h", bus.OUT_resID, bus.OUT_resPPN);

        // 5: cancel coinciding with done, then done while idle
        bus.IN_rqValid = 3'b100;
        tick();
        bus.IN_rqValid = 3'b000;
        check_eq("t5_rqID", 32'(bus.OUT_rqID), 32'd2);
        bus.IN_walkReady = 1'b1;
        tick();
        bus.IN_walkReady = 1'b0;
        bus.IN_cancel   = 3'b100;
        bus.IN_walkDone = 1'b1;
        tick();
        bus.IN_cancel   = 3'b000;
        bus.IN_walkDone = 1'b0;
        check_eq("t5_cancel_done_res", 32'(bus.OUT_resValid), 32'd0);
        check_eq("t5_cancel_done_busy", 32'(bus.OUT_busy), 32'd0);
        bus.IN_walkDone = 1'b1;
        bus.IN_walkPPN  = 22'h02222;
        tick();
        bus.IN_walkDone = 1'b0;
        check_eq("t5_idle_done_res", 32'(bus.OUT_resValid), 32'd0);
        check_eq("t5_idle_done_valid", 32'(bus.OUT_walkValid), 32'd0);
        check_eq("t5_idle_done_busy", 32'(bus.OUT_busy), 32'd0);

        // 6: reset in WAIT drops the walk and rewinds rrPtr
        bus.IN_rqValid = 3'b001;
        tick();
        bus.IN_rqValid = 3'b000;
        bus.IN_walkReady = 1'b1;
        tick();
        bus.IN_walkReady = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_busy", 32'(bus.OUT_busy), 32'd0);
        check_eq("t6_walkValid", 32'(bus.OUT_walkValid), 32'd0);
        check_eq("t6_resValid", 32'(bus.OUT_resValid), 32'd0);
        bus.IN_walkDone = 1'b1;
        tick();
        bus.IN_walkDone = 1'b0;
        check_eq("t6_late_done_res", 32'(bus.OUT_resValid), 32'd0);
        bus.IN_rqValid = 3'b111;
        tick();
        bus.IN_rqValid = 3'b000;
        check_eq("t6_rr_reset_id", 32'(bus.OUT_rqID), 32'd0);
        bus.IN_cancel = 3'b001;
        tick();
        bus.IN_cancel = 3'b000;
        check_eq("t6_cancel_valid", 32'(bus.OUT_walkValid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
